mda_glyph_fetch: RTL and testbench

//  Sequences the character-glyph ROM banks (one 512x8 EBR bank per glyph row) for the
//  MDA text path: accepts {char code, scanline} requests from the text/timing logic,

---
 rtl/mda_glyph_fetch.sv | 118 +++++++++++
 tb/tb_mda_glyph_fetch.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_glyph_fetch.sv
// MDA text-path glyph sequencer: accepts {char code, scanline} requests, reads the
// glyph ROM bank for that scanline and streams 9-pixel cells through a hold/shift pair.
module mda_glyph_fetch #(
  parameter int unsigned GLYPH_ROWS = 13,
  parameter logic [7:0]  LINEGFX_LO = 8'hC0,
  parameter logic [7:0]  LINEGFX_HI = 8'hDF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_code,
  input  logic [3:0] char_row,
  output logic [8:0] rom_raddr,
  output logic [3:0] rom_bank,
  input  logic [7:0] rom_rdata,
  input  logic       pix_adv,
  output logic       pix,
  output logic       pix_valid,
  output logic       underrun
);

  localparam logic [4:0] ROWS_L    = 5'(GLYPH_ROWS);
  localparam logic [3:0] CELL_PIXS = 4'd9;

  logic       fetch_pend_q, fetch_pend_d;
  logic       linegfx_q,    linegfx_d;
  logic [8:0] hold_q,       hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic [8:0] sreg_q,       sreg_d;
  logic [3:0] count_q,      count_d;

  logic accept;
  logic blank_row;
  logic reload;

  function automatic logic is_linegfx(input logic [7:0] code);
    return (code >= LINEGFX_LO) && (code <= LINEGFX_HI);
  endfunction

  // Column 8 repeats column 7 only for box-drawing codes so lines join across cells.
  function automatic logic [8:0] build_cell(input logic [7:0] glyph, input logic dup);
    return {glyph, dup & glyph[0]};
  endfunction

  assign rom_raddr = {1'b0, char_code};
  assign rom_bank  = char_row;

  assign char_ready = !rst && !hold_valid_q && !fetch_pend_q;
  assign pix_valid  = (count_q != 4'd0);
  assign pix        = sreg_q[8] & pix_valid;
  assign underrun   = !rst && pix_adv && (count_q == 4'd0);

  assign accept    = char_valid && char_ready;
  assign blank_row = ({1'b0, char_row} >= ROWS_L);
  // Reload on the last consumed pixel so the next cell follows with no gap.
  assign reload    = hold_valid_q &&
                     ((count_q == 4'd0) || ((count_q == 4'd1) && pix_adv));

  // NOTE: every _d gets its current value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fetch_pend_d = fetch_pend_q;
    linegfx_d    = linegfx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sreg_d       = sreg_q;
    count_d      = count_q;

    // Accept needs hold and fetch idle, so it never collides with the fetch
    // completion or the reload below.
    if (accept) begin
      if (blank_row) begin
        hold_d       = build_cell(8'h00, 1'b0);
        hold_valid_d = 1'b1;
      end else begin
        fetch_pend_d = 1'b1;
        linegfx_d    = is_linegfx(char_code);
      end
    end

    if (fetch_pend_q) begin
      hold_d       = build_cell(rom_rdata, linegfx_q);
      hold_valid_d = 1'b1;
      fetch_pend_d = 1'b0;
    end

    if (reload) begin
      sreg_d       = hold_q;
      count_d      = CELL_PIXS;
      hold_valid_d = 1'b0;
    end else if (pix_adv && (count_q != 4'd0)) begin
      sreg_d  = {sreg_q[7:0], 1'b0};
      count_d = count_q - 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pend_q <= 1'b0;
      linegfx_q    <= 1'b0;
      hold_q       <= 9'd0;
      hold_valid_q <= 1'b0;
      sreg_q       <= 9'd0;
      count_q      <= 4'd0;
    end else begin
      fetch_pend_q <= fetch_pend_d;
      linegfx_q    <= linegfx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sreg_q       <= sreg_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_mda_glyph_fetch.sv
// Self-checking bench for mda_glyph_fetch: directed scenarios plus random traffic,
// scored against a cycle-indexed pixel-queue model and a behavioural glyph ROM.
module tb_mda_glyph_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_code;
  logic [3:0] char_row;
  logic [8:0] rom_raddr;
  logic [3:0] rom_bank;
  logic [7:0] rom_rdata;
  logic       pix_adv;
  logic       pix;
  logic       pix_valid;
  logic       underrun;

  mda_glyph_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_code  (char_code),
    .char_row   (char_row),
    .rom_raddr  (rom_raddr),
    .rom_bank   (rom_bank),
    .rom_rdata  (rom_rdata),
    .pix_adv    (pix_adv),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Glyph ROM: 16 banks x 256 codes, registered read (data valid the cycle after the address edge).
  logic [7:0] rom_mem [16][256];
  bit         rom_force = 1'b0;
  always @(posedge clk) rom_rdata <= rom_force ? 8'hAA : rom_mem[rom_bank][rom_raddr[7:0]];

  // Reference model: every accepted cell becomes 9 queued pixels, each tagged with
  // the earliest cycle it may appear (fetch rows 2 cycles after accept, blank rows 1).
  typedef struct {
    logic val;
    int   avail;
    bit   first;
  } pix_t;
  pix_t q[$];

  int n_checks = 0;
  int n_fails  = 0;

  logic obs_ready, obs_valid, obs_pix, obs_under;
  logic [8:0] obs_raddr;
  logic [3:0] obs_bank;
  logic exp_ready, exp_valid, exp_pix, exp_under;
  logic rst_ready, rst_under;

  function automatic logic [8:0] cell_bits(input logic [7:0] code, input logic [3:0] row);
    logic [7:0] glyph;
    logic       c8;
    if (row < 4'd13) glyph = rom_force ? 8'hAA : rom_mem[row][code];
    else             glyph = 8'h00;
    c8 = (code >= 8'hC0 && code <= 8'hDF) ? glyph[0] : 1'b0;
    return {glyph, c8};
  endfunction

  function automatic void model_expect(input logic adv);
    int pend = 0;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    exp_pix   = exp_valid ? q[0].val : 1'b0;
    exp_under = adv && !exp_valid;
    foreach (q[i]) if (q[i].first) pend++;
    if (exp_valid && q[0].first) pend--;
    exp_ready = (pend == 0);
  endfunction

  function automatic void model_update(input logic v, input logic [7:0] code,
                                       input logic [3:0] row, input logic adv);
    logic [8:0] bits;
    int avail;
    if (v && exp_ready) begin
      bits  = cell_bits(code, row);
      avail = cyc + ((row < 4'd13) ? 3 : 2);
      for (int k = 8; k >= 0; k--) q.push_back('{val: bits[k], avail: avail, first: (k == 8)});
    end
    if (adv && exp_valid) void'(q.pop_front());
  endfunction

  // One clock of stimulus: drive at the falling edge, sample 1 ns later, advance the model.
  task automatic step(input logic v, input logic [7:0] code, input logic [3:0] row,
                      input logic adv);
    @(negedge clk);
    char_valid = v;
    char_code  = code;
    char_row   = row;
    pix_adv    = adv;
    #1;
    obs_ready = char_ready;
    obs_valid = pix_valid;
    obs_pix   = pix;
    obs_under = underrun;
    obs_raddr = rom_raddr;
    obs_bank  = rom_bank;
    model_expect(adv);
    model_update(v, code, row, adv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    char_valid = 1'b1;
    pix_adv    = 1'b1;
    #1;
    rst_ready = char_ready;
    rst_under = underrun;
    @(negedge clk);
    rst        = 1'b0;
    char_valid = 1'b0;
    pix_adv    = 1'b0;
    q.delete();
  endtask

  // Issue one request, idle until the cell appears, then consume its 9 pixels.
  task automatic run_cell(input string name, input logic [7:0] code, input logic [3:0] row,
                          output int n_wait, output logic [8:0] seq);
    n_wait = 0;
    seq    = '0;
    step(1'b1, code, row, 1'b0);
    if (obs_raddr !== {1'b0, code} || obs_bank !== row) begin
      n_fails++;
      $display("FAIL %s rom_addr got %h/%h want %h/%h", name, obs_raddr, obs_bank, {1'b0, code}, row);
    end
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 4'd0, 1'b0);
      n_wait++;
      if ({obs_ready, obs_valid, obs_pix, obs_under} !== {exp_ready, exp_valid, exp_pix, exp_under}) begin
        n_fails++;
        $display("FAIL %s_wait cyc=%0d rdy/val/pix/und got %b%b%b%b want %b%b%b%b", name, cyc,
                 obs_ready, obs_valid, obs_pix, obs_under, exp_ready, exp_valid, exp_pix, exp_under);
      end
      n_checks++;
      if (obs_valid) break;
    end
    for (int i = 8; i >= 0; i--) begin
      step(1'b0, 8'h00, 4'd0, 1'b1);
      seq[i] = obs_pix;
      if ({obs_ready, obs_valid, obs_pix, obs_under} !== {exp_ready, exp_valid, exp_pix, exp_under}) begin
        n_fails++;
        $display("FAIL %s_pix cyc=%0d rdy/val/pix/und got %b%b%b%b want %b%b%b%b", name, cyc,
                 obs_ready, obs_valid, obs_pix, obs_under, exp_ready, exp_valid, exp_pix, exp_under);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    if (rst_ready !== 1'b0 || rst_under !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_cycle ready/underrun got %b/%b want 0/0", rst_ready, rst_under);
    end
    n_checks++;
    step(1'b0, 8'h00, 4'd0, 1'b0);
    if ({obs_ready, obs_valid, obs_pix, obs_under} !== 4'b1000) begin
      n_fails++;
      $display("FAIL reset_after rdy/val/pix/und got %b%b%b%b want 1000",
               obs_ready, obs_valid, obs_pix, obs_under);
    end
    n_checks++;
  endtask

  task automatic test_basic();
    int n_wait;
    logic [8:0] seq;
    rom_mem[3][8'h41] = 8'b0001_1000;
    run_cell("basic", 8'h41, 4'd3, n_wait, seq);
    if (n_wait !== 3) begin
      n_fails++;
      $display("FAIL basic_latency cycles got %0d want 3 (2 after accepting edge)", n_wait);
    end
    n_checks++;
    if (seq !== 9'b0_0011_0000) begin
      n_fails++;
      $display("FAIL basic_seq got %b want 000110000", seq);
    end
    n_checks++;
  endtask

  task automatic test_linegfx();
    int n_wait;
    logic [8:0] seq;
    rom_mem[6][8'hC4] = 8'hFF;
    run_cell("linegfx_c4", 8'hC4, 4'd6, n_wait, seq);
    if (seq !== 9'h1FF) begin
      n_fails++;
      $display("FAIL linegfx_c4 got %b want 111111111", seq);
    end
    n_checks++;
    rom_mem[4][8'h41] = 8'hFF;
    run_cell("linegfx_41", 8'h41, 4'd4, n_wait, seq);
    if (seq !== 9'h1FE) begin
      n_fails++;
      $display("FAIL linegfx_41 got %b want 111111110", seq);
    end
    n_checks++;
    rom_mem[0][8'hDF] = 8'h01;
    run_cell("linegfx_df", 8'hDF, 4'd0, n_wait, seq);
    if (seq !== 9'h003) begin
      n_fails++;
      $display("FAIL linegfx_df got %b want 000000011", seq);
    end
    n_checks++;
  endtask

  task automatic test_blank_row();
    int n_wait;
    logic [8:0] seq;
    rom_force = 1'b1;
    run_cell("blank13", 8'hC8, 4'd13, n_wait, seq);
    if (n_wait !== 2 || seq !== 9'h000) begin
      n_fails++;
      $display("FAIL blank13 wait/seq got %0d/%b want 2/000000000", n_wait, seq);
    end
    n_checks++;
    run_cell("blank15", 8'hDB, 4'd15, n_wait, seq);
    if (n_wait !== 2 || seq !== 9'h000) begin
      n_fails++;
      $display("FAIL blank15 wait/seq got %0d/%b want 2/000000000", n_wait, seq);
    end
    n_checks++;
    rom_force = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [3] = '{8'h41, 8'hC4, 8'h7E};
    int accepts = 0, run = 0, blocked = 0, unders = 0;
    bit started = 0, done = 0;
    logic v;
    for (int i = 0; i < 60 && !done; i++) begin
      v = (accepts < 3);
      step(v, codes[accepts % 3], 4'd2, started);
      if ({obs_ready, obs_valid, obs_pix, obs_under} !== {exp_ready, exp_valid, exp_pix, exp_under}) begin
        n_fails++;
        $display("FAIL b2b cyc=%0d rdy/val/pix/und got %b%b%b%b want %b%b%b%b", cyc,
                 obs_ready, obs_valid, obs_pix, obs_under, exp_ready, exp_valid, exp_pix, exp_under);
      end
      n_checks++;
      if (v && obs_ready) accepts++;
      if (v && !obs_ready) blocked++;
      if (started && obs_valid) run++;
      if (started && obs_under && accepts < 3) unders++;
      if (started && !obs_valid) done = 1;
      if (obs_valid) started = 1;
    end
    if (run !== 27 || accepts !== 3 || unders !== 0 || !done) begin
      n_fails++;
      $display("FAIL b2b_stream run/accepts/underruns/done got %0d/%0d/%0d/%0d want 27/3/0/1",
               run, accepts, unders, done);
    end
    n_checks++;
    if (blocked == 0) begin
      n_fails++;
      $display("FAIL b2b_backpressure blocked cycles got 0 want >0");
    end
    n_checks++;
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 4'd0, 1'b1);
      if ({obs_valid, obs_pix, obs_under} !== 3'b001) begin
        n_fails++;
        $display("FAIL underrun_%0d val/pix/und got %b%b%b want 001", i, obs_valid, obs_pix, obs_under);
      end
      n_checks++;
    end
    step(1'b0, 8'h00, 4'd0, 1'b0);
    if (obs_under !== 1'b0) begin
      n_fails++;
      $display("FAIL underrun_idle got %b want 0", obs_under);
    end
    n_checks++;
  endtask

  task automatic test_reset_midcell();
    int consumed = 0, accepts = 0;
    bit started = 0;
    rom_mem[1][8'h55] = 8'hFF;
    rom_mem[2][8'h66] = 8'hFF;
    for (int i = 0; i < 40 && !(consumed == 4 && exp_valid && !exp_ready); i++) begin
      step(accepts < 2, (accepts == 0) ? 8'h55 : 8'h66, (accepts == 0) ? 4'd1 : 4'd2,
           started && consumed < 4);
      if (accepts < 2 && obs_ready) accepts++;
      if (started && consumed < 4 && obs_valid) consumed++;
      if (obs_valid) started = 1;
    end
    if (consumed !== 4 || obs_ready !== 1'b0 || accepts !== 2) begin
      n_fails++;
      $display("FAIL midcell_setup consumed/ready/accepts got %0d/%b/%0d want 4/0/2",
               consumed, obs_ready, accepts);
    end
    n_checks++;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 4'd0, 1'b0);
      if ({obs_ready, obs_valid, obs_pix} !== 3'b100) begin
        n_fails++;
        $display("FAIL midcell_after_%0d rdy/val/pix got %b%b%b want 100", i, obs_ready, obs_valid, obs_pix);
      end
      n_checks++;
    end
    step(1'b1, 8'h66, 4'd2, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 4'd0, 1'b0);
      if ({obs_ready, obs_valid, obs_pix} !== 3'b100) begin
        n_fails++;
        $display("FAIL fetch_drop_%0d rdy/val/pix got %b%b%b want 100", i, obs_ready, obs_valid, obs_pix);
      end
      n_checks++;
    end
  endtask

  task automatic test_random();
    logic v, adv;
    logic [7:0] code;
    logic [3:0] row;
    for (int i = 0; i < 800; i++) begin
      v    = ($urandom_range(0, 1) == 1);
      adv  = ($urandom_range(0, 9) < 8);
      code = 8'($urandom);
      row  = 4'($urandom_range(0, 15));
      step(v, code, row, adv);
      if ({obs_ready, obs_valid, obs_pix, obs_under} !== {exp_ready, exp_valid, exp_pix, exp_under}) begin
        n_fails++;
        $display("FAIL random cyc=%0d rdy/val/pix/und got %b%b%b%b want %b%b%b%b", cyc,
                 obs_ready, obs_valid, obs_pix, obs_under, exp_ready, exp_valid, exp_pix, exp_under);
      end
      n_checks++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_code  = 8'h00;
    char_row   = 4'd0;
    pix_adv    = 1'b0;
    for (int b = 0; b < 16; b++)
      for (int c = 0; c < 256; c++) rom_mem[b][c] = 8'($urandom);

    test_reset();
    test_basic();
    test_linegfx();
    test_blank_row();
    test_back_to_back();
    test_underrun();
    test_reset_midcell();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
